// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer slice.
package serializer_pkg;

  // Word width shared with the deserializer on the other side of the link.
  localparam int WORD_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// Shift register with bit counter: parallel load, conditional one-bit advance,
// and a flag marking that the bit currently presented is the last of the word.
module ser_shift_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    count;

  // A load wins over a shift so the next word can follow the last bit with no gap
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift <= '0;
      count <= '0;
    end else if (load) begin
      shift <= load_data;
      count <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        shift <= {shift[WIDTH-2:0], 1'b0};
      end else begin
        shift <= {1'b0, shift[WIDTH-1:1]};
      end
      count <= count + 1'b1;
    end
  end

  assign bit_out = MSB_FIRST ? shift[WIDTH-1] : shift[0];
  assign last    = (count == LAST_CNT);

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter feeding the deserializer one bit per cycle,
// with a single holding register so words can stream back to back.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_in,
  output logic             status_out,
  output logic             bit_out,
  output logic             bit_write_out,
  input  logic             ds_busy_in,
  output logic             word_done,
  output logic             drop_err
);

  ser_state_t       state;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             shift_bit;
  logic             last;
  logic             load;
  logic             accept;
  logic             last_xfer;

  assign status_out    = hold_valid;
  assign accept        = write_in && !hold_valid;
  assign bit_write_out = (state == SHIFT) && !ds_busy_in;
  assign bit_out       = (state == SHIFT) && shift_bit;
  assign last_xfer     = bit_write_out && last;
  assign load          = hold_valid && ((state == IDLE) || last_xfer);

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (hold),
    .shift_en  (bit_write_out),
    .bit_out   (shift_bit),
    .last      (last)
  );

  // Holding register, transmit FSM and the done/drop flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      word_done  <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      if (accept) begin
        hold       <= data_in;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (write_in && hold_valid) begin
        drop_err <= 1'b1;
      end

      word_done <= last_xfer;

      case (state)
        IDLE: begin
          if (hold_valid) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer && !hold_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed testbench for serializer: an MSB-first instance and an LSB-first
// instance share the same stimulus; outputs are sampled just after the falling edge.
module tb_serializer;

  logic       clock;
  logic       reset;
  logic       write_in;
  logic       ds_busy_in;
  logic [7:0] data_in;

  logic status_out, bit_out, bit_write_out, word_done, drop_err;
  logic l_status_out, l_bit_out, l_bit_write_out, l_word_done, l_drop_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp8;
  logic [15:0] exp16;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .write_in      (write_in),
    .status_out    (status_out),
    .bit_out       (bit_out),
    .bit_write_out (bit_write_out),
    .ds_busy_in    (ds_busy_in),
    .word_done     (word_done),
    .drop_err      (drop_err)
  );

  serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .write_in      (write_in),
    .status_out    (l_status_out),
    .bit_out       (l_bit_out),
    .bit_write_out (l_bit_write_out),
    .ds_busy_in    (ds_busy_in),
    .word_done     (l_word_done),
    .drop_err      (l_drop_err)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's inputs after the falling edge, then settle before checks
  task automatic applyStimulus(input logic rst_n, input logic wr, input logic [7:0] d,
                               input logic busy);
    @(negedge clock);
    reset      = rst_n;
    write_in   = wr;
    data_in    = d;
    ds_busy_in = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    reset      = 1'b0;
    write_in   = 1'b0;
    ds_busy_in = 1'b0;
    data_in    = 8'h00;

    // Reset state
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rst_status", status_out, 0);
    checkOutput("rst_bit", bit_out, 0);
    checkOutput("rst_strobe", bit_write_out, 0);
    checkOutput("rst_done", word_done, 0);
    checkOutput("rst_drop", drop_err, 0);

    // Single word 0xA5
    $display("[TB] single word 0xA5");
    exp8 = 8'b1010_0101;
    applyStimulus(1, 1, 8'hA5, 0);
    checkOutput("a5_status_c0", status_out, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("a5_status_c1", status_out, 1);
    checkOutput("a5_strobe_c1", bit_write_out, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("a5_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("a5_bit%0d", i), bit_out, exp8[7-i]);
      checkOutput($sformatf("a5_status%0d", i), status_out, 0);
      checkOutput($sformatf("a5_done%0d", i), word_done, 0);
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("a5_done_c10", word_done, 1);
    checkOutput("a5_strobe_c10", bit_write_out, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("a5_done_c11", word_done, 0);

    // Back-to-back 0x3C then 0xC3
    $display("[TB] back-to-back 0x3C 0xC3");
    exp16 = 16'b0011_1100_1100_0011;
    applyStimulus(1, 1, 8'h3C, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("b2b_status_c1", status_out, 1);
    applyStimulus(1, 1, 8'hC3, 0);
    checkOutput("b2b_status_c2", status_out, 0);
    checkOutput("b2b_strobe0", bit_write_out, 1);
    checkOutput("b2b_bit0", bit_out, exp16[15]);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("b2b_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("b2b_bit%0d", i), bit_out, exp16[15-i]);
      checkOutput($sformatf("b2b_done%0d", i), word_done, (i == 8));
      checkOutput($sformatf("b2b_status%0d", i), status_out, (i <= 7));
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("b2b_done_c18", word_done, 1);
    checkOutput("b2b_strobe_c18", bit_write_out, 0);

    // Stall on 0xF0 after the fourth bit
    $display("[TB] stall 0xF0");
    applyStimulus(1, 1, 8'hF0, 0);
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("stall_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("stall_bit%0d", i), bit_out, 1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 1);
      checkOutput($sformatf("stall_hold_strobe%0d", i), bit_write_out, 0);
      checkOutput($sformatf("stall_hold_bit%0d", i), bit_out, 0);
    end
    for (int i = 4; i < 8; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("stall_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("stall_bit%0d", i), bit_out, 0);
      checkOutput($sformatf("stall_done%0d", i), word_done, 0);
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("stall_done_c13", word_done, 1);

    // Overflow: 0x11, 0x22, then 0x33 while busy
    $display("[TB] overflow 0x11 0x22 0x33");
    exp16 = 16'h1122;
    applyStimulus(1, 1, 8'h11, 0);
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        applyStimulus(1, 1, 8'h22, 0);
        checkOutput("ovf_status_accept", status_out, 0);
      end else if (i == 1) begin
        applyStimulus(1, 1, 8'h33, 0);
        checkOutput("ovf_status_drop", status_out, 1);
      end else begin
        applyStimulus(1, 0, 8'h00, 0);
      end
      checkOutput($sformatf("ovf_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("ovf_bit%0d", i), bit_out, exp16[15-i]);
      checkOutput($sformatf("ovf_drop%0d", i), drop_err, (i >= 2));
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("ovf_done", word_done, 1);
    checkOutput("ovf_strobe_end", bit_write_out, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("ovf_idle_strobe%0d", i), bit_write_out, 0);
      checkOutput($sformatf("ovf_sticky%0d", i), drop_err, 1);
    end

    // Reset in the middle of 0xFF
    $display("[TB] reset mid-word");
    applyStimulus(1, 1, 8'hFF, 0);
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("rmid_bit%0d", i), bit_out, 1);
    end
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("rmid_strobe", bit_write_out, 0);
    checkOutput("rmid_status", status_out, 0);
    checkOutput("rmid_drop", drop_err, 0);
    checkOutput("rmid_done", word_done, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("rmid_strobe2", bit_write_out, 0);
    exp8 = 8'b1000_0001;
    applyStimulus(1, 1, 8'h81, 0);
    applyStimulus(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("r81_strobe%0d", i), bit_write_out, 1);
      checkOutput($sformatf("r81_bit%0d", i), bit_out, exp8[7-i]);
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("r81_done", word_done, 1);

    // 0x01 on both instances: LSB-first sends a 1 then seven 0s
    $display("[TB] bit order 0x01");
    exp8 = 8'b0000_0001;
    applyStimulus(1, 1, 8'h01, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("lsb_status_c1", l_status_out, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'h00, 0);
      checkOutput($sformatf("lsb_strobe%0d", i), l_bit_write_out, 1);
      checkOutput($sformatf("lsb_bit%0d", i), l_bit_out, (i == 0));
      checkOutput($sformatf("msb01_bit%0d", i), bit_out, exp8[7-i]);
    end
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("lsb_done", l_word_done, 1);
    checkOutput("lsb_drop", l_drop_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Transmit-side counterpart of the deserializer.
- Accepts parallel WIDTH-bit words through a write/busy handshake.
- Emits each word one bit per cycle as a bit plus write strobe.
- Pauses whenever the downstream deserializer reports busy.
- Sits between the word producer and the deserializer's data_in/write_in/status_out interface.
- Runs at the 100 kHz system clock.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clock  input  1  system clock, 100 kHz, rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in  input  WIDTH  parallel word from producer.
- write_in  input  1  producer offers data_in this cycle.
- status_out  output  1  1 = busy, word not accepted; 0 = can accept.
- bit_out  output  1  serial data bit to deserializer.
- bit_write_out  output  1  bit_out is valid this cycle; deserializer stores it.
- ds_busy_in  input  1  deserializer status_out; 1 = do not send.
- word_done  output  1  one-cycle pulse after the last bit of a word is transferred.
- drop_err  output  1  sticky; write_in seen while status_out = 1.

Behaviour:
- Reset: sampled only on a clock edge with reset = 0. At that edge, clear all of the following:
  - hold register, hold_valid, shift register, bit counter;
  - state -> IDLE, status_out = 0, bit_out = 0, bit_write_out = 0, word_done = 0, drop_err = 0.
  - A partially sent word is discarded; no further strobes follow.
- Storage: one holding register (hold, hold_valid) plus one shift register with a bit counter of clog2(WIDTH) bits.
- Accept:
  - status_out = hold_valid (registered).
  - If write_in = 1 and status_out = 0 at an edge, data_in is captured into hold and hold_valid is set.
  - If write_in = 1 and status_out = 1, the word is ignored and drop_err is set until reset.
- FSM state IDLE:
  - bit_write_out = 0.
  - If hold_valid: copy hold into the shift register, clear hold_valid, set count = 0, go to SHIFT.
- FSM state SHIFT:
  - bit_out = shift[WIDTH-1] if MSB_FIRST, else shift[0] (combinational from the register).
  - bit_write_out = ~ds_busy_in.
  - When bit_write_out = 1 at an edge: shift by one, count++.
  - When ds_busy_in = 1: shift and count hold, and bit_out stays stable.
- Last bit (count = WIDTH-1 transferred):
  - word_done is registered high for the next cycle.
  - If hold_valid: reload the shift register from hold, clear hold_valid, stay in SHIFT with count = 0. Words go out back-to-back with no gap cycle.
  - Otherwise go to IDLE.
- Latency: write accepted at cycle 0 edge → hold_valid in cycle 1 → first bit_write_out in cycle 2 (if ds_busy_in = 0) → last bit in cycle WIDTH+1 → word_done in cycle WIDTH+2.
- Simultaneous hold release and write_in in the same cycle: status_out is still 1, so the write is dropped. Producers must honour status_out.
- ds_busy_in is ignored in IDLE. In SHIFT it may stay high indefinitely; there is no timeout.
- data_in is don't-care whenever write_in = 0.

Decomposition:
- serializer_pkg contains:
  - typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;
  - localparam WORD_W = 8, shared with the deserializer.
- One natural sub-module: ser_shift_reg.
  - Function: parallel load, conditional shift, bit counter, last-bit flag, direction selected by MSB_FIRST.
  - The top-level block keeps the hold register, FSM and flags.

Test Plan:
- Single word, ds_busy_in = 0: write 0xA5 at cycle 0 → bit_write_out high in cycles 2–9 with bits 1,0,1,0,0,1,0,1; word_done in cycle 10; status_out high only in cycle 1.
- Back-to-back: write 0x3C, then 0xC3 as soon as status_out = 0 → 16 consecutive bit_write_out cycles (00111100 11000011) with no gap; two word_done pulses, 8 cycles apart.
- Stall: 0xF0, ds_busy_in high for 3 cycles after the 4th bit → bit_write_out low and bit_out stable for those cycles; the remaining bits are 0000; word_done at cycle 13.
- Overflow: write 0x11, 0x22, then 0x33 while status_out = 1 → 0x33 never appears serially; drop_err = 1 until reset; 0x11 and 0x22 are sent intact.
- Reset mid-word: reset low for 1 edge after 4 bits of 0xFF → from the next cycle bit_write_out = 0, status_out = 0, drop_err = 0; a new 0x81 is then sent fully and correctly.
- MSB_FIRST = 0: write 0x01 → first transferred bit is 1, followed by seven 0s.
